// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer for a 32-bit word-addressed data memory with registered inputs.
// It turns RV32I byte/half/word requests into word accesses, using read-modify-write for SB/SH.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_w_enable,
  output logic        mem_r_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_DATA, ST_RD, ST_MERGE, ST_WRITE, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        bad_f3, misaligned, out_of_range, fault;
  logic [31:0] word_idx;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign word_idx  = {2'b00, req_addr[31:2]};

  always_comb begin
    if (req_we) bad_f3 = (req_funct3 >= 3'd3);
    else        bad_f3 = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    misaligned   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    out_of_range = (word_idx >= 32'(MEM_WORDS));
    fault        = bad_f3 || misaligned || out_of_range;
  end

  // Load alignment: pick the addressed lane, then sign- or zero-extend by funct3.
  always_comb begin
    ld_byte = 8'h00;
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_val = {24'h0, ld_byte};
      3'd5:    load_val = {16'h0, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Store merge: each byte lane is either kept from memory or taken from the store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic hit;
    logic [7:0] src;
    assign hit = funct3_q[0] ? (off_q[1] == LANE[1]) : (off_q == LANE);
    assign src = funct3_q[0] ? wdata_q[LANE[0]*8 +: 8] : wdata_q[7:0];
    assign merged[gi*8 +: 8] = hit ? src : mem_rdata[gi*8 +: 8];
  end

  always_comb begin
    state_d      = state_q;
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    resp_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault)                  state_d = RESP;
          else if (!req_we)           state_d = LD_ISSUE;
          else if (req_funct3 == 3'd2) state_d = ST_WRITE;
          else                        state_d = ST_RD;
        end
      end
      LD_ISSUE: begin
        mem_r_enable = 1'b1;
        state_d      = LD_DATA;
      end
      LD_DATA:  state_d = RESP;
      ST_RD: begin
        mem_r_enable = 1'b1;
        state_d      = ST_MERGE;
      end
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: begin
        mem_w_enable = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= 16'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q   <= req_funct3;
        off_q      <= req_addr[1:0];
        wdata_q    <= req_wdata[15:0];
        err_q      <= fault;
        rdata_q    <= 32'h0;
        mem_addr_q <= word_idx;
        if (req_we && (req_funct3 == 3'd2) && !fault) mem_wdata_q <= req_wdata;
      end
      if (state_q == LD_DATA)  rdata_q     <= load_val;
      if (state_q == ST_MERGE) mem_wdata_q <= merged;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered-input word memory model attached.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_w_enable, mem_r_enable;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: inputs registered; write commits one edge after sampling, read data the cycle after.
  logic [31:0] mem_model [128];
  logic        m_we_s;
  logic [6:0]  m_a_s;
  logic [31:0] m_d_s;
  always @(posedge clk) begin
    if (m_we_s) mem_model[m_a_s] <= m_d_s;
    m_we_s <= mem_w_enable;
    m_a_s  <= mem_addr[6:0];
    m_d_s  <= mem_wdata;
    if (mem_r_enable) mem_rdata <= mem_model[mem_addr[6:0]];
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd, output int wcnt, output int rcnt,
                        output logic [31:0] maddr);
    lat = -1; err = 1'b0; rd = 32'h0; wcnt = 0; rcnt = 0; maddr = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int k = 0; k < 20 && !req_ready; k++) begin
      @(posedge clk); #1;
    end
    if (req_ready) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        wcnt += int'(mem_w_enable);
        rcnt += int'(mem_r_enable);
        if (n == 1) maddr = mem_addr;
        if (resp_valid) begin
          lat = n; err = resp_err; rd = resp_rdata;
          break;
        end
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    $display("[TB] we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h wen=%0d ren=%0d",
             we, f3, addr, wd, lat, err, rd, wcnt, rcnt);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_in_rst got %b want 0", req_ready); end
    @(posedge clk); #1;
    tests_run++; if ({resp_valid, resp_err, mem_w_enable, mem_r_enable} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags got %b want 0000", {resp_valid, resp_err, mem_w_enable, mem_r_enable}); end
    tests_run++; if (resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after got %b want 1", req_ready); end
  endtask

  task automatic test_sw_lw;
    int lat, wc, rc; logic e; logic [31:0] rd, ma;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, e, rd, wc, rc, ma);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL sw_latency got %0d want 2", lat); end
    tests_run++; if (wc !== 1) begin tests_failed++; $display("FAIL sw_wen_cycles got %0d want 1", wc); end
    tests_run++; if (rc !== 0) begin tests_failed++; $display("FAIL sw_ren_cycles got %0d want 0", rc); end
    tests_run++; if (ma !== 32'h4) begin tests_failed++; $display("FAIL sw_mem_addr got %h want 4", ma); end
    tests_run++; if ({e, rd} !== 33'h0) begin tests_failed++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", e, rd); end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL lw_latency got %0d want 3", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL lw_err got %b want 0", e); end
    tests_run++; if (rc !== 1 || wc !== 0) begin tests_failed++; $display("FAIL lw_enables got r=%0d w=%0d want 1/0", rc, wc); end
  endtask

  task automatic test_byte;
    int lat, wc, rc; logic e; logic [31:0] rd, ma;
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, lat, e, rd, wc, rc, ma);
    do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, lat, e, rd, wc, rc, ma);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL sb_latency got %0d want 4", lat); end
    tests_run++; if (wc !== 1 || rc !== 1) begin tests_failed++; $display("FAIL sb_enables got w=%0d r=%0d want 1/1", wc, rc); end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'hA5223344) begin tests_failed++; $display("FAIL sb_word got %h want a5223344", rd); end
    do_req(1'b0, 3'd0, 32'h13, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'hFFFFFFA5) begin tests_failed++; $display("FAIL lb_sign got %h want ffffffa5", rd); end
    do_req(1'b0, 3'd4, 32'h13, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'h000000A5) begin tests_failed++; $display("FAIL lbu_zero got %h want 000000a5", rd); end
  endtask

  task automatic test_half;
    int lat, wc, rc; logic e; logic [31:0] rd, ma;
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, lat, e, rd, wc, rc, ma);
    do_req(1'b1, 3'd1, 32'h12, 32'h0000BEEF, lat, e, rd, wc, rc, ma);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL sh_latency got %0d want 4", lat); end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'hBEEF3344) begin tests_failed++; $display("FAIL sh_word got %h want beef3344", rd); end
    do_req(1'b0, 3'd1, 32'h12, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'hFFFFBEEF) begin tests_failed++; $display("FAIL lh_sign got %h want ffffbeef", rd); end
    do_req(1'b0, 3'd5, 32'h12, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'h0000BEEF) begin tests_failed++; $display("FAIL lhu_zero got %h want 0000beef", rd); end
    do_req(1'b0, 3'd1, 32'h10, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'h00003344) begin tests_failed++; $display("FAIL lh_low got %h want 00003344", rd); end
    // Only the low byte of the store data may land, in lane 1.
    do_req(1'b1, 3'd0, 32'h11, 32'h000012FF, lat, e, rd, wc, rc, ma);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'hBEEFFF44) begin tests_failed++; $display("FAIL sb_lane1_word got %h want beefff44", rd); end
  endtask

  task automatic test_faults;
    int lat, wc, rc; logic e; logic [31:0] rd, ma;
    logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3_t [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
    logic [31:0] ad_t [4] = '{32'h11, 32'h13, 32'h200, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_req(we_t[i], f3_t[i], ad_t[i], 32'hFFFFFFFF, lat, e, rd, wc, rc, ma);
      tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL fault%0d_latency got %0d want 1", i, lat); end
      tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL fault%0d_err got %b want 1", i, e); end
      tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL fault%0d_rdata got %h want 0", i, rd); end
      tests_run++; if (wc !== 0 || rc !== 0) begin tests_failed++; $display("FAIL fault%0d_enables got w=%0d r=%0d want 0/0", i, wc, rc); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] rd;
    lat = -1; rd = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h5;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_idle got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'h0;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_st_write got %b want 0", req_ready); end
    @(posedge clk); #1;
    tests_run++; if ({resp_valid, req_ready} !== 2'b10) begin tests_failed++; $display("FAIL b2b_sw_resp got valid,ready=%b want 10", {resp_valid, req_ready}); end
    @(posedge clk); #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_after_resp got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (resp_valid) begin lat = n; rd = resp_rdata; break; end
      @(posedge clk); #1;
    end
    $display("[TB] b2b SW 0x20=5 then LW 0x20 -> lat=%0d rdata=%h", lat, rd);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL b2b_lw_latency got %0d want 3", lat); end
    tests_run++; if (rd !== 32'h5) begin tests_failed++; $display("FAIL b2b_lw_rdata got %h want 5", rd); end
  endtask

  task automatic test_reset_mid_op;
    int lat, wc, rc; logic e; logic [31:0] rd, ma;
    logic wseen, vseen;
    do_req(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, lat, e, rd, wc, rc, ma);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h30; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wseen = mem_w_enable;
    @(posedge clk); #1;
    wseen |= mem_w_enable;
    rst = 1'b1;
    #1;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_ready_in_rst got %b want 0", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready_after got %b want 1", req_ready); end
    vseen = resp_valid;
    wseen |= mem_w_enable;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      vseen |= resp_valid;
      wseen |= mem_w_enable;
    end
    $display("[TB] SB 0x30 aborted by reset -> resp_seen=%0d wen_seen=%0d", vseen, wseen);
    tests_run++; if (vseen !== 1'b0) begin tests_failed++; $display("FAIL midrst_resp got %b want 0", vseen); end
    tests_run++; if (wseen !== 1'b0) begin tests_failed++; $display("FAIL midrst_wen got %b want 0", wseen); end
    do_req(1'b0, 3'd2, 32'h30, 32'h0, lat, e, rd, wc, rc, ma);
    tests_run++; if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL midrst_word got %h want cafef00d", rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
